// File: rtl/cp0_compare_timer_pkg.sv
// cp0_compare_timer_pkg: shared address/reset constants and timer state encoding
package cp0_compare_timer_pkg;

    localparam logic [5:0]  CP0ADDR_COMPARE = 6'd11;
    localparam logic [31:0] COMPARE_INI_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        TI_UNARMED = 2'd0,
        TI_ARMED   = 2'd1,
        TI_PENDING = 2'd2
    } ti_state_e;

endpackage

// File: rtl/cp0_compare_timer_if.sv
// cp0_compare_timer_if: MTC0 write bus plus Compare read-back
interface cp0_compare_timer_if;

    logic        mtc0_we;
    logic [5:0]  cp0_addr;
    logic [31:0] mtc0_data;
    logic [31:0] cp0_Compare_data;

    modport master (output mtc0_we, cp0_addr, mtc0_data, input cp0_Compare_data);
    modport slave  (input mtc0_we, cp0_addr, mtc0_data, output cp0_Compare_data);

endinterface

// File: rtl/cp0_match_edge.sv
// cp0_match_edge: Count==Compare comparator with rising-edge detect
module cp0_match_edge (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        armed,
    input  logic        wr_cmp,
    input  logic [31:0] count_data,
    input  logic [31:0] compare_data,
    output logic        rise
);

    logic match;
    logic match_d;
    logic match_q;

    // A Compare write forces the history bit high so the write cycle's own match is not an edge
    always_comb begin
        match   = armed && (count_data == compare_data);
        match_d = wr_cmp || match;
        rise    = match && !match_q;
    end

    // Match history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) match_q <= 1'b0;
        else        match_q <= match_d;
    end

endmodule

// File: rtl/cp0_compare_timer.sv
// cp0_compare_timer: CP0 Compare register, Cause.TI pending flag and timer interrupt request
// CP0_TI_MASK_EN: when defined, timer_int_req is gated by Status.IM7/IE/EXL; otherwise unmasked.
module cp0_compare_timer
    import cp0_compare_timer_pkg::*;
#(
    parameter logic [31:0] COMPARE_INI  = COMPARE_INI_DEF,
    parameter logic [5:0]  ADDR_COMPARE = CP0ADDR_COMPARE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cp0_compare_timer_if.slave        bus,
    input  logic [31:0]               count_data,
    input  logic                      status_ie,
    input  logic                      status_exl,
    input  logic                      status_im7,
    output logic                      cause_ti,
    output logic                      timer_int_req
);

    ti_state_e   state_d, state_q;
    logic [31:0] compare_d, compare_q;
    logic        timer_int_req_d, timer_int_req_q;
    logic        wr_cmp;
    logic        armed;
    logic        rise;
`ifndef CP0_TI_MASK_EN
    logic        unused_status;
`endif

    cp0_match_edge u_match_edge (
        .clk          (clk),
        .rst_n        (rst_n),
        .armed        (armed),
        .wr_cmp       (wr_cmp),
        .count_data   (count_data),
        .compare_data (compare_q),
        .rise         (rise)
    );

    // Next-state: a Compare write always wins over a simultaneous match edge
    always_comb begin
        wr_cmp    = bus.mtc0_we && (bus.cp0_addr == ADDR_COMPARE);
        armed     = state_q != TI_UNARMED;
        cause_ti  = state_q == TI_PENDING;
        compare_d = wr_cmp ? bus.mtc0_data : compare_q;
        state_d   = wr_cmp ? TI_ARMED :
                    (state_q == TI_ARMED && rise) ? TI_PENDING : state_q;
`ifdef CP0_TI_MASK_EN
        timer_int_req_d = cause_ti && status_im7 && status_ie && !status_exl;
`else
        unused_status   = ^{status_ie, status_exl, status_im7};
        timer_int_req_d = cause_ti;
`endif
    end

    // State, Compare and request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= TI_UNARMED;
            compare_q       <= COMPARE_INI;
            timer_int_req_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            compare_q       <= compare_d;
            timer_int_req_q <= timer_int_req_d;
        end
    end

    assign bus.cp0_Compare_data = compare_q;
    assign timer_int_req        = timer_int_req_q;

endmodule

// File: tb/tb_cp0_compare_timer.sv
// tb_cp0_compare_timer: randomized scoreboard bench for cp0_compare_timer
module tb_cp0_compare_timer;

    typedef struct packed {
        logic        ti;
        logic        req;
        logic [31:0] cmp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] count_data;
    logic        status_ie, status_exl, status_im7;
    logic        cause_ti, timer_int_req;

    cp0_compare_timer_if bus ();

    cp0_compare_timer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .count_data    (count_data),
        .status_ie     (status_ie),
        .status_exl    (status_exl),
        .status_im7    (status_im7),
        .cause_ti      (cause_ti),
        .timer_int_req (timer_int_req)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    exp_t        mon_e;
    int          passed = 0;
    int          total  = 0;

    // reference model: pending flag, armed flag, Compare value, request,
    // and whether the current Count==Compare event has already been consumed
    logic        m_armed, m_pend, m_seen, m_req;
    logic [31:0] m_cmp;
    logic [31:0] cnt;
    bit          half;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_armed = 0; m_pend = 0; m_seen = 0; m_req = 0; m_cmp = 32'h0;
    endtask

    // drive one cycle of stimulus, update the model at the clock edge and queue the expectation
    task automatic cyc(input bit we, input bit [5:0] addr, input bit [31:0] d);
        bit wr, eq, mask;
        bus.mtc0_we   = we;
        bus.cp0_addr  = addr;
        bus.mtc0_data = d;
        count_data    = cnt;
        @(posedge clk);
        wr = we && addr == 6'd11;
        eq = m_armed && cnt == m_cmp;
`ifdef CP0_TI_MASK_EN
        mask = status_ie && status_im7 && !status_exl;
`else
        mask = 1'b1;
`endif
        m_req = m_pend && mask;
        if (wr) begin
            m_cmp = d; m_armed = 1; m_pend = 0;
        end else if (eq && !m_seen) begin
            m_pend = 1;
        end
        m_seen = wr || eq;
        sb.push_back('{ti: m_pend, req: m_req, cmp: m_cmp});
        #1;
        bus.mtc0_we = 1'b0;
        if (half) cnt++;
        half = !half;
    endtask

    task automatic idle();
        cyc(1'b0, 6'd0, 32'h0);
    endtask

    task automatic run_to(input logic [31:0] target);
        for (int i = 0; i < 400 && cnt != target; i++) idle();
        if (cnt != target) chk("run_to_bound", cnt, target);
    endtask

    // monitor: outputs are valid every cycle, so compare one expectation per falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("cause_ti", {31'b0, cause_ti}, {31'b0, mon_e.ti});
            chk("timer_int_req", {31'b0, timer_int_req}, {31'b0, mon_e.req});
            chk("compare", bus.cp0_Compare_data, mon_e.cmp);
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.mtc0_we = 0; bus.cp0_addr = 0; bus.mtc0_data = 0;
        count_data = 0; status_ie = 1; status_im7 = 1; status_exl = 0;
        cnt = 0; half = 0;
        model_reset();
        #12;
        chk("reset_ti", {31'b0, cause_ti}, 32'd0);
        chk("reset_req", {31'b0, timer_int_req}, 32'd0);
        chk("reset_compare", bus.cp0_Compare_data, 32'h0);
        rst_n = 1'b1;

        // unarmed: Count passes Compare=0 repeatedly without setting TI
        run_to(32'd5);
        // arm at Count=5, match at 0x10, stays pending across holds and 0x11
        cyc(1'b1, 6'd11, 32'h10);
        run_to(32'h12);
        // Count writes never touch Compare or TI
        cyc(1'b1, 6'd9, 32'hDEAD_BEEF);
        // rewrite while pending clears TI, sets again at 0x20
        cyc(1'b1, 6'd11, 32'h20);
        run_to(32'h21);
        // write Compare equal to the live Count value: no set this event
        run_to(32'h30);
        cyc(1'b1, 6'd11, 32'h30);
        run_to(32'h32);
        // wrap around 2^32 back to 0x30
        cnt = 32'hFFFF_FFFE; half = 0;
        repeat (6) idle();
        cnt = 32'h2E; half = 0;
        run_to(32'h31);
        // status masking while pending
        status_ie = 1; status_im7 = 1; status_exl = 0;
        repeat (2) idle();
        status_exl = 1;
        repeat (2) idle();
        status_exl = 0; status_im7 = 0;
        repeat (2) idle();
        status_im7 = 1;
        idle();

        // asynchronous reset in the middle of PENDING
        @(negedge clk); #1;
        chk("pending_before_reset", {31'b0, cause_ti}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_ti", {31'b0, cause_ti}, 32'd0);
        chk("async_req", {31'b0, timer_int_req}, 32'd0);
        chk("async_compare", bus.cp0_Compare_data, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // randomized traffic around the live Count value
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) status_ie  = 1'($urandom);
            if ($urandom_range(0, 7) == 0) status_exl = 1'($urandom);
            if ($urandom_range(0, 7) == 0) status_im7 = 1'($urandom);
            if (!half && $urandom_range(0, 63) == 0) cnt = $urandom;
            case ($urandom_range(0, 15))
                0:       cyc(1'b1, 6'd11, cnt + 32'($urandom_range(0, 6)));
                1:       cyc(1'b1, 6'd11, cnt);
                2:       cyc(1'b1, 6'($urandom), $urandom);
                default: idle();
            endcase
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
